snake_tick_scheduler: RTL
=========================

Name: snake_tick_scheduler

Overview:
Game-timing controller for the snake game. Sequences a two-stage counter chain: a clock prescaler producing a 1 ms strobe, then a millisecond counter producing the snake move tick. Owns the game run state (idle/run/paused/over) and the speed level, and issues move requests to the snake-update datapath with a req/ack handshake.

Parameters:
CLK_DIV_MAX, 99999, prescaler terminal count; one ms strobe every CLK_DIV_MAX+1 clocks (1 kHz at 100 MHz).
BASE_PERIOD_MS, 250, move period at level 0, in ms.
STEP_MS, 20, period reduction per level, in ms.
MIN_PERIOD_MS, 50, floor on move period, in ms; must be >=1 and <=BASE_PERIOD_MS.
LEVEL_WIDTH, 4, width of the level register.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
START_IN  in  1  one-cycle pulse; start new game
PAUSE_TOGGLE_IN  in  1  one-cycle pulse; toggle run/paused
GAME_OVER_IN  in  1  one-cycle pulse from collision logic
LEVEL_UP_IN  in  1  one-cycle pulse; increase speed level
MOVE_ACK_IN  in  1  datapath has consumed current move request
MOVE_REQ_OUT  out  1  move request, held until acknowledged
MISSED_TICK_OUT  out  1  one-cycle pulse: tick arrived while request still pending
STATE_OUT  out  2  0=IDLE, 1=RUN, 2=PAUSED, 3=OVER
LEVEL_OUT  out  LEVEL_WIDTH  current speed level
PERIOD_MS_OUT  out  10  current move period in ms

Behaviour:
- Reset (RESET=1 at a clock edge): STATE=IDLE, level=0, prescaler=0, ms counter=0, MOVE_REQ_OUT=0, MISSED_TICK_OUT=0, PERIOD_MS_OUT=BASE_PERIOD_MS. Reset overrides all inputs.
- State transitions, evaluated in priority order GAME_OVER_IN > START_IN > PAUSE_TOGGLE_IN:
  IDLE: START -> RUN. PAUSE and GAME_OVER ignored.
  RUN: GAME_OVER -> OVER; PAUSE -> PAUSED; START ignored.
  PAUSED: GAME_OVER -> OVER; PAUSE -> RUN; START ignored.
  OVER: START -> RUN. All others ignored.
- Entering RUN from IDLE/OVER: level, prescaler, ms counter, MOVE_REQ_OUT all cleared on the same edge.
- Entering OVER: prescaler, ms counter, MOVE_REQ_OUT cleared; level held for display.
- Prescaler advances only in RUN: counts 0..CLK_DIV_MAX, wraps to 0. ms strobe is asserted on the wrap cycle.
- ms counter advances on ms strobe only: counts 0..PERIOD-1, wraps to 0. Move tick is asserted on that wrap.
- First tick therefore occurs PERIOD*(CLK_DIV_MAX+1) clocks after the edge on which STATE_OUT became RUN. MOVE_REQ_OUT is registered and rises on the edge that tick is sampled.
- PAUSED: prescaler, ms counter and MOVE_REQ_OUT frozen. MOVE_ACK_IN is still honoured and clears the request. Resume continues the count with no loss.
- Handshake: a tick sets MOVE_REQ_OUT. MOVE_ACK_IN=1 while MOVE_REQ_OUT=1 clears it next edge. ACK while REQ=0 is ignored.
  - Tick while REQ=1 and no ACK that cycle: REQ stays 1, MISSED_TICK_OUT=1 for one cycle.
  - Tick and ACK in the same cycle: REQ stays 1 (new request), no miss.
- Period: PERIOD = BASE_PERIOD_MS - level*STEP_MS if level*STEP_MS <= BASE_PERIOD_MS - MIN_PERIOD_MS, else MIN_PERIOD_MS. Compute without underflow, using width >= LEVEL_WIDTH+10. Registered into PERIOD_MS_OUT one cycle after a level change.
- LEVEL_UP_IN: honoured in RUN and PAUSED only. Increments level, saturating at 2^LEVEL_WIDTH-1. The ms counter is not reset.
  - If the ms counter is >= new PERIOD-1 when the next strobe arrives, that strobe wraps the counter and ticks. No overshoot past the period.
- LEVEL_UP coincident with a transition to OVER or a restart: the transition wins and the level is not incremented.

Test Plan:
(Params CLK_DIV_MAX=3, BASE=10, STEP=2, MIN=4, LEVEL_WIDTH=4.)
- RESET for 2 cycles, then START pulse -> STATE_OUT=1 next edge; MOVE_REQ_OUT rises exactly 40 clocks later; PERIOD_MS_OUT=10; MISSED_TICK_OUT stays 0.
- Hold MOVE_ACK_IN=0 across two periods -> REQ stays 1; MISSED_TICK_OUT pulses once at clock 80. ACK one cycle -> REQ=0 next edge. ACK coincident with a tick -> REQ stays 1, no miss pulse.
- 3 LEVEL_UP pulses -> LEVEL_OUT=3, PERIOD_MS_OUT=4. Fourth and fifth pulses -> PERIOD stays 4. 16 pulses total -> LEVEL_OUT saturates at 15.
- PAUSE at 20 clocks into a period, hold 100 clocks, PAUSE again -> STATE 1->2->1; REQ rises 20 clocks after resume; ACK during pause clears REQ.
- GAME_OVER and PAUSE in the same cycle during RUN -> STATE_OUT=3, REQ=0, level held. START -> STATE=1, LEVEL_OUT=0, PERIOD=10, fresh 40-clock first tick.
- RESET asserted mid-period with REQ=1 and level=2 -> all outputs at reset values next edge; START in IDLE with PAUSE in the same cycle -> RUN (START wins).

Source files
------------

// File: rtl/snake_tick_scheduler.sv
// Snake game timing controller: prescaler -> ms counter -> move tick,
// run-state FSM, speed level and move req/ack handshake.
module snake_tick_scheduler #(
    parameter int CLK_DIV_MAX    = 99999,
    parameter int BASE_PERIOD_MS = 250,
    parameter int STEP_MS        = 20,
    parameter int MIN_PERIOD_MS  = 50,
    parameter int LEVEL_WIDTH    = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START_IN,
    input  logic                   PAUSE_TOGGLE_IN,
    input  logic                   GAME_OVER_IN,
    input  logic                   LEVEL_UP_IN,
    input  logic                   MOVE_ACK_IN,
    output logic                   MOVE_REQ_OUT,
    output logic                   MISSED_TICK_OUT,
    output logic [1:0]             STATE_OUT,
    output logic [LEVEL_WIDTH-1:0] LEVEL_OUT,
    output logic [9:0]             PERIOD_MS_OUT
);

    localparam int PS_W = (CLK_DIV_MAX > 0) ? $clog2(CLK_DIV_MAX + 1) : 1;
    localparam int PW   = LEVEL_WIDTH + 16;

    localparam logic [PS_W-1:0]        PS_MAX  = PS_W'(CLK_DIV_MAX);
    localparam logic [PW-1:0]          SLACK   = PW'(BASE_PERIOD_MS - MIN_PERIOD_MS);
    localparam logic [PW-1:0]          BASE_W  = PW'(BASE_PERIOD_MS);
    localparam logic [PW-1:0]          STEP_W  = PW'(STEP_MS);
    localparam logic [LEVEL_WIDTH-1:0] LVL_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_OVER   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PS_W-1:0]        ps_q, ps_d;
    logic [9:0]             ms_q, ms_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [9:0]             period_q, period_d;
    logic                   req_q, req_d;
    logic                   miss_q, miss_d;

    logic                   restart;
    logic                   to_over;
    logic                   strobe;
    logic                   tick;
    logic [PW-1:0]          reduce;

    // Run-state transitions; game over beats start beats pause.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        to_over = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START_IN) begin
                    state_d = S_RUN;
                    restart = 1'b1;
                end
            end
            S_RUN: begin
                if (GAME_OVER_IN) begin
                    state_d = S_OVER;
                    to_over = 1'b1;
                end else if (PAUSE_TOGGLE_IN) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (GAME_OVER_IN) begin
                    state_d = S_OVER;
                    to_over = 1'b1;
                end else if (PAUSE_TOGGLE_IN) begin
                    state_d = S_RUN;
                end
            end
            S_OVER: begin
                if (START_IN) begin
                    state_d = S_RUN;
                    restart = 1'b1;
                end
            end
        endcase
    end

    // Counter chain, handshake, level and period next-state.
    always_comb begin
        ps_d     = ps_q;
        ms_d     = ms_q;
        req_d    = req_q;
        miss_d   = 1'b0;
        level_d  = level_q;
        strobe   = (state_q == S_RUN) && (ps_q == PS_MAX);
        // >= so a level-up that shrinks the period below the count
        // wraps on the next strobe instead of overshooting.
        tick     = strobe && (ms_q >= (period_q - 10'd1));
        reduce   = PW'(level_q) * STEP_W;
        period_d = (reduce <= SLACK) ? 10'(BASE_W - reduce)
                                     : 10'(MIN_PERIOD_MS);

        if (restart || to_over) begin
            ps_d = '0;
            ms_d = '0;
        end else if (state_q == S_RUN) begin
            ps_d = strobe ? '0 : ps_q + 1'b1;
            if (strobe) begin
                ms_d = tick ? 10'd0 : ms_q + 10'd1;
            end
        end

        if (restart || to_over) begin
            req_d = 1'b0;
        end else if (tick) begin
            req_d  = 1'b1;
            miss_d = req_q && !MOVE_ACK_IN;
        end else if (MOVE_ACK_IN && req_q) begin
            req_d = 1'b0;
        end

        if (restart) begin
            level_d = '0;
        end else if (LEVEL_UP_IN && !to_over &&
                     (state_q == S_RUN || state_q == S_PAUSED) &&
                     level_q != LVL_MAX) begin
            level_d = level_q + 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            ps_q     <= '0;
            ms_q     <= '0;
            level_q  <= '0;
            period_q <= 10'(BASE_PERIOD_MS);
            req_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ps_q     <= ps_d;
            ms_q     <= ms_d;
            level_q  <= level_d;
            period_q <= period_d;
            req_q    <= req_d;
            miss_q   <= miss_d;
        end
    end

    assign MOVE_REQ_OUT    = req_q;
    assign MISSED_TICK_OUT = miss_q;
    assign STATE_OUT       = state_q;
    assign LEVEL_OUT       = level_q;
    assign PERIOD_MS_OUT   = period_q;

endmodule
